// File: rtl/rope_pkg.sv
// rope_pkg: shared rope status encoding, channel/scheduler state types and LFSR step
package rope_pkg;

   localparam int ROPES_DEFAULT = 6;

   // Status seen by the monkey movement block; 2'b11 is never driven.
   typedef enum logic [1:0] {
      E_OFF  = 2'b00,
      E_WARN = 2'b01,
      E_LIVE = 2'b10
   } eStatusT;

   typedef enum logic [1:0] {
      CH_OFF,
      CH_WARN,
      CH_ON,
      CH_COOL
   } chStateT;

   typedef enum logic [1:0] {
      S_IDLE,
      S_GAP,
      S_PICK
   } schedStateT;

   function automatic logic [7:0] lfsrStep(input logic [7:0] v);
      return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
   endfunction

endpackage

// File: rtl/rope_electro_channel.sv
// rope_electro_channel: one rope's OFF -> WARN -> ON -> COOL frame sequencer
module rope_electro_channel
   import rope_pkg::*;
#(
   parameter int WARN_FRAMES = 45,
   parameter int ON_FRAMES   = 90,
   parameter int COOL_FRAMES = 60
) (
   input  logic    clk,
   input  logic    resetN,
   input  logic    tick,
   input  logic    kill,
   input  logic    start,
   output eStatusT status,
   output logic    busy
);

   chStateT    state, stateNext;
   logic [7:0] cnt, cntNext;

   // kill wins; an idle rope arms on start, busy phases count down on ticks
   always_comb begin
      stateNext = state;
      cntNext   = cnt;
      if (kill) begin
         stateNext = CH_OFF;
         cntNext   = '0;
      end else if (state == CH_OFF) begin
         if (start) begin
            stateNext = CH_WARN;
            cntNext   = 8'(WARN_FRAMES);
         end
      end else if (tick) begin
         if (cnt != 8'd1) cntNext = cnt - 8'd1;
         else begin
            case (state)
               CH_WARN: begin
                  stateNext = CH_ON;
                  cntNext   = 8'(ON_FRAMES);
               end
               CH_ON: begin
                  stateNext = CH_COOL;
                  cntNext   = 8'(COOL_FRAMES);
               end
               default: begin
                  stateNext = CH_OFF;
                  cntNext   = '0;
               end
            endcase
         end
      end
   end

   // phase and frame counter registers
   always_ff @(posedge clk or negedge resetN)
      if (!resetN) begin
         state <= CH_OFF;
         cnt   <= '0;
      end else begin
         state <= stateNext;
         cnt   <= cntNext;
      end

   // status trails the phase by one clk; kill clears it together with the phase
   always_ff @(posedge clk or negedge resetN)
      if (!resetN) status <= E_OFF;
      else status <= kill ? E_OFF : state == CH_WARN ? E_WARN : state == CH_ON ? E_LIVE : E_OFF;

   assign busy = state != CH_OFF;

   // the scheduler only starts ropes it has seen idle
   assert property (@(posedge clk) disable iff (!resetN) start |-> state == CH_OFF);

endmodule

// File: rtl/rope_electro_scheduler.sv
// rope_electro_scheduler: picks ropes pseudo-randomly and runs their electrify sequence
module rope_electro_scheduler
   import rope_pkg::*;
#(
   parameter int         ROPES       = ROPES_DEFAULT,
   parameter int         MAX_ACTIVE  = 2,
   parameter int         WARN_FRAMES = 45,
   parameter int         ON_FRAMES   = 90,
   parameter int         COOL_FRAMES = 60,
   parameter int         GAP_FRAMES  = 60,
   parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
   input  logic                  clk,
   input  logic                  resetN,
   input  logic                  startOfFrame,
   input  logic                  enable,
   input  logic                  pause,
   output logic [ROPES-1:0][1:0] electroStatus,
   output logic [ROPES-1:0]      busy,
   output logic [3:0]            activeCount
);

   localparam int         IDXW    = $clog2(ROPES);
   localparam logic [7:0] GAP8    = 8'(GAP_FRAMES);
   localparam logic [3:0] MAXACT4 = 4'(MAX_ACTIVE);

   if (ROPES < 2 || ROPES > 15 || MAX_ACTIVE < 1 || MAX_ACTIVE > ROPES ||
       WARN_FRAMES < 1 || WARN_FRAMES > 255 || ON_FRAMES < 1 || ON_FRAMES > 255 ||
       COOL_FRAMES < 1 || COOL_FRAMES > 255 || GAP_FRAMES < 1 || GAP_FRAMES > 255 ||
       LFSR_SEED == 8'h00) begin : gBadParams
      $error("rope_electro_scheduler: illegal parameter set");
   end

   logic            tick;
   logic            kill;
   logic [7:0]      lfsr;
   logic [IDXW-1:0] pickIdx;
   schedStateT      sched, schedNext;
   logic [7:0]      gap, gapNext;
   logic [ROPES-1:0] start;

   assign tick    = startOfFrame & enable & ~pause;
   assign kill    = ~enable;
   assign pickIdx = IDXW'(lfsr % 8'(ROPES));

   // LFSR moves only on effective ticks and is held, not reseeded, while disabled
   always_ff @(posedge clk or negedge resetN)
      if (!resetN) lfsr <= LFSR_SEED;
      else if (tick) lfsr <= lfsrStep(lfsr);

   // busy ropes counted from pre-tick state so a pick can never exceed the cap
   always_comb begin
      activeCount = '0;
      for (int i = 0; i < ROPES; i++) activeCount = activeCount + 4'(busy[i]);
   end

   // scheduler: idle until enabled, wait the gap, then retry picks every tick
   always_comb begin
      schedNext = sched;
      gapNext   = gap;
      start     = '0;
      if (!enable) schedNext = S_IDLE;
      else begin
         case (sched)
            S_IDLE: begin
               schedNext = S_GAP;
               gapNext   = GAP8;
            end
            S_GAP: if (tick) begin
               if (gap == 8'd1) schedNext = S_PICK;
               else gapNext = gap - 8'd1;
            end
            S_PICK: if (tick && !busy[pickIdx] && activeCount < MAXACT4) begin
               start[pickIdx] = 1'b1;
               gapNext        = GAP8;
               schedNext      = S_GAP;
            end
            default: schedNext = S_IDLE;
         endcase
      end
   end

   // scheduler state and gap counter
   always_ff @(posedge clk or negedge resetN)
      if (!resetN) begin
         sched <= S_IDLE;
         gap   <= '0;
      end else begin
         sched <= schedNext;
         gap   <= gapNext;
      end

   for (genvar i = 0; i < ROPES; i++) begin : gCh
      rope_electro_channel #(
         .WARN_FRAMES(WARN_FRAMES),
         .ON_FRAMES  (ON_FRAMES),
         .COOL_FRAMES(COOL_FRAMES)
      ) uCh (
         .clk   (clk),
         .resetN(resetN),
         .tick  (tick),
         .kill  (kill),
         .start (start[i]),
         .status(electroStatus[i]),
         .busy  (busy[i])
      );
   end

endmodule

// File: tb/tb_rope_electro_scheduler.sv
// tb_rope_electro_scheduler: directed timeline checks plus a long random invariant run
module tb_rope_electro_scheduler;
   import rope_pkg::*;

   localparam int W = 2, O = 3, C = 2, G = 4;

   logic            clk = 1'b0;
   logic            resetN, startOfFrame, enable, pause;
   logic [5:0][1:0] electroStatus, es1;
   logic [5:0]      busy, busy1;
   logic [3:0]      activeCount, ac1;

   int assertCount = 0;
   int failCount   = 0;

   always #5 clk = ~clk;

   rope_electro_scheduler #(
      .ROPES(6), .MAX_ACTIVE(2), .WARN_FRAMES(W), .ON_FRAMES(O),
      .COOL_FRAMES(C), .GAP_FRAMES(G), .LFSR_SEED(8'hA5)
   ) dut (
      .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .enable(enable),
      .pause(pause), .electroStatus(electroStatus), .busy(busy), .activeCount(activeCount)
   );

   rope_electro_scheduler #(
      .ROPES(6), .MAX_ACTIVE(1), .WARN_FRAMES(W), .ON_FRAMES(O),
      .COOL_FRAMES(C), .GAP_FRAMES(G), .LFSR_SEED(8'hA5)
   ) dut1 (
      .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .enable(enable),
      .pause(pause), .electroStatus(es1), .busy(busy1), .activeCount(ac1)
   );

   task automatic assertEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      assertCount++;
      if (got !== exp) begin
         failCount++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic int durOf(input int p);
      return p == 1 ? W : p == 2 ? O : C;
   endfunction

   task automatic frame();
      @(negedge clk) startOfFrame = 1'b1;
      @(negedge clk) startOfFrame = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic frames(input int n);
      repeat (n) frame();
   endtask

   task automatic startGame();
      @(negedge clk) enable = 1'b1;
      @(negedge clk);
   endtask

   task automatic doReset();
      enable = 1'b0;
      pause  = 1'b0;
      resetN = 1'b0;
      repeat (2) @(negedge clk);
      resetN = 1'b1;
      @(negedge clk);
   endtask

   // random-run observer: status trails state by a clk, so the phase after edge e-1 is
   // rebuilt from this sample's status and the previous busy sample
   logic       tickQ, enQ, tickLast;
   logic       monOn = 1'b0;
   logic [5:0] busyLast;
   int         rPrev [6];
   int         cnt   [6];
   bit         inval [6];

   always @(posedge clk) begin
      tickQ <= startOfFrame & enable & ~pause;
      enQ   <= enable;
   end

   always @(negedge clk) if (monOn) begin
      bit bad0, bad1;
      bad0 = 1'b0;
      bad1 = 1'b0;
      for (int i = 0; i < 6; i++) begin
         bad0 |= electroStatus[i] == 2'b11;
         bad1 |= es1[i] == 2'b11;
      end
      assertEq("no11", bad0, 0);
      assertEq("no11Max1", bad1, 0);
      assertEq("acCap", activeCount <= 4'd2, 1);
      assertEq("acCapMax1", ac1 <= 4'd1, 1);
      assertEq("acPop", activeCount, $countones(busy));
      assertEq("acPopMax1", ac1, $countones(busy1));
      for (int i = 0; i < 6; i++) begin
         int r;
         r = electroStatus[i] == 2'b01 ? 1 : electroStatus[i] == 2'b10 ? 2 : busyLast[i] ? 3 : 0;
         if (!enQ) inval[i] = 1'b1;
         else if (inval[i]) begin
            if (r == 0 && rPrev[i] == 0) begin
               inval[i] = 1'b0;
               cnt[i]   = 0;
            end
         end else begin
            if (tickLast && rPrev[i] != 0) cnt[i]++;
            if (r != rPrev[i]) begin
               assertEq($sformatf("seqRope%0d", i), r, (rPrev[i] + 1) % 4);
               if (rPrev[i] != 0) assertEq($sformatf("durRope%0d", i), cnt[i], durOf(rPrev[i]));
               cnt[i] = 0;
            end
         end
         rPrev[i] = r;
      end
      busyLast = busy;
      tickLast = tickQ;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      resetN = 1'b0; startOfFrame = 1'b0; enable = 1'b0; pause = 1'b0;
      repeat (3) @(negedge clk);
      resetN = 1'b1;
      @(negedge clk);
      assertEq("rstStatus", electroStatus, 0);
      assertEq("rstBusy", busy, 0);
      assertEq("rstCount", activeCount, 0);
      assertEq("rstLfsr", dut.lfsr, 8'hA5);
      assertEq("rstSched", dut.sched, S_IDLE);

      // first pick, then an asynchronous reset while rope 0 is in WARN
      startGame();
      assertEq("gapAfterEnable", dut.sched, S_GAP);
      frames(4);
      assertEq("lfsrSof4", dut.lfsr, 8'h54);
      assertEq("pickSof4", dut.sched, S_PICK);
      assertEq("idleSof4", electroStatus, 0);
      frame();
      assertEq("warnSof5", electroStatus, 12'h001);
      assertEq("busySof5", busy, 6'b000001);
      #2 resetN = 1'b0;
      #1;
      assertEq("asyncRstStatus", electroStatus, 0);
      assertEq("asyncRstBusy", busy, 0);
      assertEq("asyncRstCount", activeCount, 0);
      assertEq("asyncRstLfsr", dut.lfsr, 8'hA5);
      assertEq("asyncRstSched", dut.sched, S_IDLE);
      enable = 1'b0;
      @(negedge clk) resetN = 1'b1;
      @(negedge clk);

      // full timeline; the MAX_ACTIVE=1 instance shares the stimulus
      startGame();
      frames(5);
      assertEq("t1Sof5", electroStatus, 12'h001);
      assertEq("t1Sof5Count", activeCount, 1);
      assertEq("t1Sof5Max1", es1, 12'h001);
      frame();
      assertEq("t1Sof6", electroStatus, 12'h001);
      frame();
      assertEq("t1Sof7", electroStatus, 12'h002);
      frames(2);
      assertEq("t1Sof9", electroStatus, 12'h002);
      frame();
      assertEq("t1Sof10", electroStatus, 12'h004);
      assertEq("t1Sof10Busy", busy, 6'b000011);
      assertEq("t1Sof10Count", activeCount, 2);
      assertEq("t1Sof10Max1", es1, 12'h000);
      assertEq("t1Sof10Max1Busy", busy1, 6'b000001);
      assertEq("t1Sof10Max1Count", ac1, 1);
      frames(2);
      assertEq("t1Sof12", electroStatus, 12'h008);
      assertEq("t1Sof12Busy", busy, 6'b000010);
      assertEq("t1Sof12Count", activeCount, 1);
      assertEq("t1Sof12Max1Busy", busy1, 6'b000000);
      assertEq("t1Sof12Max1Count", ac1, 0);
      frame();
      assertEq("t1Sof13", electroStatus, 12'h008);
      assertEq("t1Sof13Max1", es1, 12'h100);
      assertEq("t1Sof13Max1Busy", busy1, 6'b010000);
      assertEq("t1Sof13Max1Count", ac1, 1);

      // pause freezes rope 0 in WARN and the LFSR
      doReset();
      startGame();
      frames(5);
      assertEq("pzSof5", electroStatus, 12'h001);
      assertEq("pzLfsr5", dut.lfsr, 8'hA9);
      pause = 1'b1;
      frames(3);
      assertEq("pzHeldStatus", electroStatus, 12'h001);
      assertEq("pzHeldLfsr", dut.lfsr, 8'hA9);
      assertEq("pzHeldBusy", busy, 6'b000001);
      assertEq("pzHeldSched", dut.sched, S_GAP);
      pause = 1'b0;
      frame();
      assertEq("pzResume1", electroStatus, 12'h001);
      frame();
      assertEq("pzResume2", electroStatus, 12'h002);
      assertEq("pzResumeLfsr", dut.lfsr, 8'hA7);

      // enable drop while rope 0 is live, then re-enable with a full gap
      @(negedge clk) enable = 1'b0;
      @(negedge clk);
      assertEq("killStatus", electroStatus, 0);
      assertEq("killBusy", busy, 0);
      assertEq("killCount", activeCount, 0);
      assertEq("killSched", dut.sched, S_IDLE);
      assertEq("killLfsrHeld", dut.lfsr, 8'hA7);
      repeat (3) @(negedge clk);
      startGame();
      frames(4);
      assertEq("reenSof4", electroStatus, 0);
      assertEq("reenSof4Sched", dut.sched, S_PICK);
      assertEq("reenSof4Lfsr", dut.lfsr, 8'h77);
      frame();
      assertEq("reenSof5", electroStatus, 12'h400);
      assertEq("reenSof5Busy", busy, 6'b100000);

      // long random run with random pause and enable
      doReset();
      for (int i = 0; i < 6; i++) begin
         rPrev[i] = 0;
         cnt[i]   = 0;
         inval[i] = 1'b1;
      end
      busyLast = busy;
      tickLast = 1'b0;
      @(negedge clk);
      monOn  = 1'b1;
      enable = 1'b1;
      for (int f = 0; f < 10000; f++) begin
         pause = $urandom_range(0, 7) == 0;
         if (!enable) enable = $urandom_range(0, 2) == 0;
         else if ($urandom_range(0, 249) == 0) enable = 1'b0;
         frame();
      end
      monOn = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/rope_electro_scheduler.md
Name: rope_electro_scheduler

Overview:
- Drives the per-rope `electroStatus` vector that the monkey movement/collision block consumes. A monkey touching a rope whose status is 2'b10 is frozen.
- Decides when and which rope gets electrified: pseudo-random rope choice, a warning phase, a live phase and a cooldown phase.
- Caps the number of simultaneously busy ropes.
- Sits between game-state control and the monkey/rope datapath. All timing is in frames, counted on `startOfFrame` (SOF).

Parameters:
- ROPES, 6, number of ropes; must match the movement block.
- MAX_ACTIVE, 2, maximum ropes not in OFF at once.
- WARN_FRAMES, 45, frames in WARN; must be ≥1.
- ON_FRAMES, 90, frames live (status 2'b10); must be ≥1.
- COOL_FRAMES, 60, frames in COOL before the rope can be reselected; must be ≥1.
- GAP_FRAMES, 60, frames between scheduling attempts; must be ≥1.
- LFSR_SEED, 8'hA5, LFSR reset value; must be nonzero.

Ports:
- clk, in, 1, system clock.
- resetN, in, 1, asynchronous active-low reset.
- startOfFrame, in, 1, one-clk pulse per frame.
- enable, in, 1, game running; 0 forces everything OFF.
- pause, in, 1, freezes all counters, the scheduler and the LFSR; outputs hold.
- electroStatus, out, [ROPES-1:0][1:0], per-rope status:
  - 00 = off or cool
  - 01 = warning
  - 10 = electrified
  - 11 = never driven
- busy, out, ROPES, per-rope state != OFF.
- activeCount, out, 4, number of busy ropes (popcount of `busy`).

Behaviour:
- Reset (async):
  - all channels OFF; `electroStatus`=0, `busy`=0, `activeCount`=0
  - scheduler in S_IDLE, gap counter 0
  - lfsr=LFSR_SEED
- Tick definition: an effective tick is SOF && enable && !pause. All counters, FSM frame transitions and LFSR updates happen only on effective ticks.
- LFSR:
  - 8-bit, shift left, new bit0 = b7^b5^b4^b3.
  - Advances on every effective tick.
  - pickIdx = lfsr % ROPES, using the pre-advance value in the same cycle.
- Scheduler FSM {S_IDLE, S_GAP, S_PICK}:
  - S_IDLE: when enable=1, go to S_GAP on the next clk and load gap=GAP_FRAMES. This transition is not tick-gated.
  - S_GAP: on tick, if gap==1 go to S_PICK, else gap-1.
  - S_PICK: on tick, if !busy[pickIdx] && activeCount<MAX_ACTIVE:
    - assert start[pickIdx] for that single clk
    - load gap=GAP_FRAMES and go to S_GAP
  - S_PICK otherwise: stay and retry on the next tick with the new LFSR value.
  - enable=0 in any state: go to S_IDLE on the next clk.
- Channel FSM {OFF, WARN, ON, COOL}, one per rope:
  - OFF + start: go to WARN, cnt=WARN_FRAMES, same clk as start.
  - WARN/ON/COOL on tick: if cnt==1, advance (WARN→ON with ON_FRAMES, ON→COOL with COOL_FRAMES, COOL→OFF); else cnt-1.
  - Status mapping is registered from state: OFF/COOL→00, WARN→01, ON→10.
  - The status update lands in the clk after the transition edge.
  - start while not OFF is ignored (cannot occur by construction; assert).
- enable falling edge:
  - all channels go to OFF and the scheduler to S_IDLE on the next clk
  - the LFSR is held, not reseeded
  - re-enable restarts with a full GAP
- pause: no state or counter changes. A start pulse cannot occur because PICK is tick-gated.
- Simultaneity:
  - A channel leaving COOL→OFF on the same tick as a PICK of that rope: the PICK sees busy=1 (pre-tick state), so no start.
  - activeCount is evaluated on pre-tick state, so MAX_ACTIVE is never exceeded.
- Widths:
  - frame counters 8 bits; every *_FRAMES must be ≤255 (elaboration assert)
  - activeCount saturates structurally, since ROPES ≤15

Decomposition:
- Shared package `rope_pkg`:
  - typedef enum logic [1:0] for E_OFF=2'b00, E_WARN=2'b01, E_LIVE=2'b10, shared with the movement block
  - default ROPES constant
  - the channel state enum
- Sub-module `rope_electro_channel`: one instance per rope via generate.
  - Inputs: clk, resetN, tick, kill (=!enable), start.
  - Outputs: status, busy.
  - Parameters: WARN/ON/COOL frame counts.
- Top level holds the scheduler FSM, LFSR, modulo and popcount.

Test Plan (WARN=2, ON=3, COOL=2, GAP=4, MAX_ACTIVE=2, seed A5; SOFs counted after enable rises, none in the enable clk):
- Reset mid-WARN → all outputs 0 immediately (async), lfsr=A5, FSM S_IDLE.
- First pick: LFSR after 4 SOFs is A5→4A→95→2A→54 (84%6=0).
  - SOF5 starts rope 0: status[0]=01 after SOF5.
  - 10 after SOF7; 00 (COOL, busy=1) after SOF10.
  - busy[0]=0 after SOF12.
  - All other ropes stay 00 throughout.
- pause=1 held across SOF6–SOF8 → rope 0 remains 01 and lfsr is unchanged; the timeline resumes shifted by 3 frames.
- enable dropped while rope 0=10 → next clk all status 00, busy=0, S_IDLE; re-enable requires 4 SOFs before the next pick.
- MAX_ACTIVE=1 build → while rope 0 is busy, S_PICK retries every SOF with no start pulse and activeCount stays 1; a start is issued only after rope 0 returns to OFF.
- Long random run (10k frames, random pause/enable) → checks that:
  - electroStatus never equals 11
  - activeCount ≤ MAX_ACTIVE
  - every rope follows the sequence 01→10→00 with exact durations
